// File: rtl/branch_resolve_tracker.sv
// In-order tracker of predicted branches: trains the predictor and redirects on mispredict.
// Outputs registered one cycle after resolve; stall_fetch is raised while all DEPTH entries are in flight.
module branch_resolve_tracker #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        fetch_valid,
    input  logic        fetch_is_branch,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_is_rv32c,
    input  logic        predict_taken,
    input  logic [31:0] target_addr,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        flush,
    output logic        stall_fetch,
    output logic        update_predictor,
    output logic [31:0] pc_to_update,
    output logic [31:0] update_addr,
    output logic        branch_result,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        resolve_err
);

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        rv32c;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    entry_t           fifo [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    entry_t      head_entry;
    entry_t      new_entry;
    logic        push;
    logic        pop;
    logic        mis;
    logic        clear;
    logic [31:0] next_pc;

    assign stall_fetch = (count == FULL);
    assign head_entry  = fifo[head];
    assign new_entry   = '{pc: fetch_pc, pred_taken: predict_taken,
                           pred_target: target_addr, rv32c: fetch_is_rv32c};

    assign push  = fetch_valid & fetch_is_branch & ~stall_fetch;
    assign pop   = resolve_valid & (count != '0);
    assign mis   = pop & ((head_entry.pred_taken != resolve_taken) |
                          (resolve_taken & (head_entry.pred_target != resolve_target)));
    // A mispredict or trap kills every younger entry, including one arriving this cycle.
    assign clear = flush | mis;

    assign next_pc = resolve_taken ? resolve_target
                                   : head_entry.pc + (head_entry.rv32c ? 32'd2 : 32'd4);

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo[tail] <= new_entry;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            update_predictor <= 1'b0;
            mispredict       <= 1'b0;
            pc_to_update     <= '0;
            update_addr      <= '0;
            branch_result    <= 1'b0;
            redirect_pc      <= '0;
            resolve_err      <= 1'b0;
        end else begin
            update_predictor <= pop;
            mispredict       <= mis;
            if (pop) begin
                pc_to_update  <= head_entry.pc;
                update_addr   <= resolve_target;
                branch_result <= resolve_taken;
                redirect_pc   <= next_pc;
            end
            if (resolve_valid && count == '0) begin
                resolve_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker with hand-computed expectations.
module tb_branch_resolve_tracker;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        fetch_valid, fetch_is_branch, fetch_is_rv32c, predict_taken;
    logic [31:0] fetch_pc, target_addr;
    logic        resolve_valid, resolve_taken, flush;
    logic [31:0] resolve_target;
    logic        stall_fetch, update_predictor, branch_result, mispredict, resolve_err;
    logic [31:0] pc_to_update, update_addr, redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    branch_resolve_tracker #(.DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .fetch_valid(fetch_valid), .fetch_is_branch(fetch_is_branch),
        .fetch_pc(fetch_pc), .fetch_is_rv32c(fetch_is_rv32c),
        .predict_taken(predict_taken), .target_addr(target_addr),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .flush(flush),
        .stall_fetch(stall_fetch), .update_predictor(update_predictor),
        .pc_to_update(pc_to_update), .update_addr(update_addr),
        .branch_result(branch_result), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .resolve_err(resolve_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0; fetch_is_branch = 1'b0; fetch_pc = '0; fetch_is_rv32c = 1'b0;
        predict_taken = 1'b0; target_addr = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0; flush = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic c);
        fetch_valid = 1'b1; fetch_is_branch = 1'b1; fetch_pc = pc;
        predict_taken = pt; target_addr = tgt; fetch_is_rv32c = c;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        resolve_valid = 1'b1; resolve_taken = taken; resolve_target = tgt;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] drain_pc [4] = '{32'h404, 32'h408, 32'h40C, 32'h450};

    initial begin
        idle();
        nRST = 1'b0;
        #3;
        chk("rst_stall", {31'd0, stall_fetch}, 32'd0);
        chk("rst_upd",   {31'd0, update_predictor}, 32'd0);
        chk("rst_mis",   {31'd0, mispredict}, 32'd0);
        chk("rst_err",   {31'd0, resolve_err}, 32'd0);
        chk("rst_pc",    pc_to_update, 32'd0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;
        step();

        // correctly predicted taken branch
        fetch(32'h100, 1'b1, 32'h200, 1'b0); step(); idle();
        resolve(1'b1, 32'h200); step(); idle();
        chk("hit_upd",  {31'd0, update_predictor}, 32'd1);
        chk("hit_pc",   pc_to_update, 32'h100);
        chk("hit_addr", update_addr, 32'h200);
        chk("hit_dir",  {31'd0, branch_result}, 32'd1);
        chk("hit_mis",  {31'd0, mispredict}, 32'd0);
        step();
        chk("hit_upd_drop", {31'd0, update_predictor}, 32'd0);
        chk("hit_pc_hold",  pc_to_update, 32'h100);

        // direction mispredicts and sequential-PC redirects
        fetch(32'h100, 1'b0, 32'h102, 1'b1); step(); idle();
        resolve(1'b1, 32'h180); step(); idle();
        chk("mis_nt_flag", {31'd0, mispredict}, 32'd1);
        chk("mis_nt_pc",   redirect_pc, 32'h180);
        step();
        chk("mis_pulse_drop", {31'd0, mispredict}, 32'd0);
        fetch(32'h100, 1'b1, 32'h200, 1'b0); step(); idle();
        resolve(1'b0, 32'h300); step(); idle();
        chk("mis_t_flag", {31'd0, mispredict}, 32'd1);
        chk("mis_t_pc",   redirect_pc, 32'h104);
        chk("mis_t_dir",  {31'd0, branch_result}, 32'd0);
        fetch(32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0); step(); idle();
        resolve(1'b0, 32'h40); step(); idle();
        chk("mis_wrap_pc", redirect_pc, 32'h0);

        // fill to full, push while full is dropped even with a pop
        for (int i = 0; i < 4; i++) begin
            fetch(32'h400 + 32'(4 * i), 1'b1, 32'h500, 1'b0); step(); idle();
            chk("fill_stall", {31'd0, stall_fetch}, (i == 3) ? 32'd1 : 32'd0);
        end
        fetch(32'h440, 1'b1, 32'h500, 1'b0); resolve(1'b1, 32'h500); step(); idle();
        chk("full_pop_upd",   {31'd0, update_predictor}, 32'd1);
        chk("full_pop_pc",    pc_to_update, 32'h400);
        chk("full_pop_stall", {31'd0, stall_fetch}, 32'd0);
        fetch(32'h450, 1'b1, 32'h500, 1'b0); step(); idle();
        chk("refill_stall", {31'd0, stall_fetch}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            resolve(1'b1, 32'h500); step();
            chk("drain_pc",  pc_to_update, drain_pc[i]);
            chk("drain_mis", {31'd0, mispredict}, 32'd0);
        end
        idle();

        // mispredict flushes younger entries and the same-cycle push
        fetch(32'h10, 1'b0, 32'h0, 1'b0); step();
        fetch(32'h20, 1'b0, 32'h0, 1'b0); step();
        fetch(32'h30, 1'b0, 32'h0, 1'b0); step(); idle();
        fetch(32'h40, 1'b0, 32'h0, 1'b0); resolve(1'b1, 32'h80); step(); idle();
        chk("mflush_mis", {31'd0, mispredict}, 32'd1);
        chk("mflush_pc",  redirect_pc, 32'h80);
        chk("mflush_err", {31'd0, resolve_err}, 32'd0);
        resolve(1'b1, 32'h80); step(); idle();
        chk("empty_upd", {31'd0, update_predictor}, 32'd0);
        chk("empty_err", {31'd0, resolve_err}, 32'd1);
        step();
        chk("err_sticky", {31'd0, resolve_err}, 32'd1);

        // external flush with push and pop in the same cycle
        fetch(32'h600, 1'b1, 32'h700, 1'b0); step();
        fetch(32'h610, 1'b1, 32'h700, 1'b0); step(); idle();
        flush = 1'b1; fetch(32'h620, 1'b1, 32'h700, 1'b0); resolve(1'b1, 32'h700); step(); idle();
        chk("flush_upd", {31'd0, update_predictor}, 32'd1);
        chk("flush_pc",  pc_to_update, 32'h600);
        chk("flush_mis", {31'd0, mispredict}, 32'd0);
        resolve(1'b1, 32'h700); step(); idle();
        chk("flush_empty_upd", {31'd0, update_predictor}, 32'd0);

        // async reset mid-operation
        fetch(32'h800, 1'b0, 32'h0, 1'b0); step();
        fetch(32'h804, 1'b0, 32'h0, 1'b0); step();
        fetch(32'h808, 1'b0, 32'h0, 1'b0); step(); idle();
        resolve(1'b1, 32'h900); step(); idle();
        chk("pre_rst_mis", {31'd0, mispredict}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("arst_upd",   {31'd0, update_predictor}, 32'd0);
        chk("arst_mis",   {31'd0, mispredict}, 32'd0);
        chk("arst_pc",    pc_to_update, 32'd0);
        chk("arst_addr",  update_addr, 32'd0);
        chk("arst_redir", redirect_pc, 32'd0);
        chk("arst_err",   {31'd0, resolve_err}, 32'd0);
        chk("arst_stall", {31'd0, stall_fetch}, 32'd0);
        #1 nRST = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            fetch(32'hA00 + 32'(4 * i), 1'b1, 32'hB00, 1'b0); step(); idle();
            chk("post_rst_stall", {31'd0, stall_fetch}, (i == 3) ? 32'd1 : 32'd0);
        end
        resolve(1'b1, 32'hB00); step(); idle();
        chk("post_rst_pc", pc_to_update, 32'hA00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
